reg_bank: RTL and testbench

- 8-entry x 8-bit general-purpose register file for the single-cycle mini-processor datapath.
- Two combinational read ports feed the ALU operands; one synchronous write port is driven by the writeback stage.
- The processor issues a write every cycle, so there is no write enable; the controller steers unused writes to a scratch register.

---
 rtl/reg_bank_pkg.sv | 12 +
 rtl/reg_bank_read_port.sv | 33 +++
 rtl/reg_bank.sv | 42 ++++
 tb/tb_reg_bank.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared widths and types for the mini-processor register file, decoder and ALU.
// Optional build macro REG_BANK_BYPASS_EN is consumed by reg_bank_read_port.
package reg_bank_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_bank_read_port.sv
// One combinational read port: NUM_REGS:1 mux, forced to zero while in reset.
// Build macro REG_BANK_BYPASS_EN adds write-through forwarding from the write port.
module reg_bank_read_port
  import reg_bank_pkg::*;
(
  input  logic                      rst_n,
  input  reg_data_t [NUM_REGS-1:0]  regs,
  input  reg_idx_t                  rd_idx,
  input  reg_idx_t                  wr_idx,
  input  reg_data_t                 wr_data,
  output reg_data_t                 rd_data
);

`ifdef REG_BANK_BYPASS_EN
  always_comb begin
    rd_data = '0;
    if (rst_n) begin
      // The value being written this cycle wins over the stale stored value.
      if (rd_idx == wr_idx) rd_data = wr_data;
      else                  rd_data = regs[rd_idx];
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_idx, wr_data};

  always_comb begin
    rd_data = '0;
    if (rst_n) rd_data = regs[rd_idx];
  end
`endif

endmodule

// File: rtl/reg_bank.sv
// 8x8 register file: two combinational read ports, one write every rising edge (no enable).
// Build macro REG_BANK_BYPASS_EN enables same-cycle write-through on both read ports.
module reg_bank
  import reg_bank_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  output reg_data_t readData1,
  output reg_data_t readData2,
  input  reg_idx_t  readRegister1,
  input  reg_idx_t  readRegister2,
  input  reg_idx_t  writeRegister,
  input  reg_data_t writeData
);

  reg_data_t [NUM_REGS-1:0] regs;

  // The controller parks unused writes on a scratch register, so every edge writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs <= '0;
    else        regs[writeRegister] <= writeData;
  end

  reg_bank_read_port u_read_port1 (
    .rst_n   (rst_n),
    .regs    (regs),
    .rd_idx  (readRegister1),
    .wr_idx  (writeRegister),
    .wr_data (writeData),
    .rd_data (readData1)
  );

  reg_bank_read_port u_read_port2 (
    .rst_n   (rst_n),
    .regs    (regs),
    .rd_idx  (readRegister2),
    .wr_idx  (writeRegister),
    .wr_data (writeData),
    .rd_data (readData2)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Directed table-driven bench for reg_bank; each table row is one clock cycle whose write commits at its end.
module tb_reg_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] readData1, readData2;
  logic [2:0] readRegister1, readRegister2, writeRegister;
  logic [7:0] writeData;

  int checks = 0;
  int errors = 0;

  reg_bank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .readData1     (readData1),
    .readData2     (readData2),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .writeRegister (writeRegister),
    .writeData     (writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values are the pre-edge reads of the base build (stored contents only).
  typedef struct {
    logic [2:0] wr;
    logic [7:0] wd;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [2:0] wr, input logic [7:0] wd,
                              input logic [2:0] r1, input logic [2:0] r2,
                              input logic [7:0] e1, input logic [7:0] e2);
    vec_t v;
    v.wr = wr; v.wd = wd; v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] x1, x2;

    vecs[0]  = mk(3'd1,   8'd66, 3'd1, 3'd4,   8'd0,   8'd0);
    vecs[1]  = mk(3'd4,    8'd2, 3'd1, 3'd4,  8'd66,   8'd0);
    vecs[2]  = mk(3'd5,   8'd33, 3'd4, 3'd1,   8'd2,  8'd66);
    vecs[3]  = mk(3'd0,    8'd7, 3'd5, 3'd4,  8'd33,   8'd2);
    vecs[4]  = mk(3'd1,   8'd15, 3'd1, 3'd1,  8'd66,  8'd66);
    vecs[5]  = mk(3'd2,   8'd23, 3'd0, 3'd1,   8'd7,  8'd15);
    vecs[6]  = mk(3'd3,   8'd31, 3'd2, 3'd5,  8'd23,  8'd33);
    vecs[7]  = mk(3'd4,   8'd39, 3'd3, 3'd4,  8'd31,   8'd2);
    vecs[8]  = mk(3'd5,   8'd47, 3'd4, 3'd5,  8'd39,  8'd33);
    vecs[9]  = mk(3'd6,   8'd55, 3'd5, 3'd6,  8'd47,   8'd0);
    vecs[10] = mk(3'd7,   8'd63, 3'd6, 3'd7,  8'd55,   8'd0);
    vecs[11] = mk(3'd0,    8'd7, 3'd0, 3'd7,   8'd7,  8'd63);
    vecs[12] = mk(3'd1,   8'd15, 3'd1, 3'd6,  8'd15,  8'd55);
    vecs[13] = mk(3'd2,   8'd23, 3'd2, 3'd5,  8'd23,  8'd47);
    vecs[14] = mk(3'd3,   8'd31, 3'd3, 3'd4,  8'd31,  8'd39);
    vecs[15] = mk(3'd4,   8'd39, 3'd4, 3'd3,  8'd39,  8'd31);
    vecs[16] = mk(3'd5,   8'd47, 3'd5, 3'd2,  8'd47,  8'd23);
    vecs[17] = mk(3'd6,   8'd55, 3'd6, 3'd1,  8'd55,  8'd15);
    vecs[18] = mk(3'd7,   8'd63, 3'd7, 3'd0,  8'd63,   8'd7);
    vecs[19] = mk(3'd0,    8'd7, 3'd0, 3'd0,   8'd7,   8'd7);
    vecs[20] = mk(3'd1,  8'd200, 3'd1, 3'd0,  8'd15,   8'd7);
    vecs[21] = mk(3'd1,  8'd255, 3'd1, 3'd2, 8'd200,  8'd23);
    vecs[22] = mk(3'd7,   8'd63, 3'd1, 3'd1, 8'd255, 8'd255);

    rst_n = 1'b0;
    writeRegister = 3'd0;
    writeData = 8'd0;
    readRegister1 = 3'd0;
    readRegister2 = 3'd1;
    #2;
    check("reset_rd1", readData1, 8'd0);
    check("reset_rd2", readData2, 8'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      writeRegister = vecs[i].wr;
      writeData     = vecs[i].wd;
      readRegister1 = vecs[i].r1;
      readRegister2 = vecs[i].r2;
      x1 = vecs[i].e1;
      x2 = vecs[i].e2;
`ifdef REG_BANK_BYPASS_EN
      if (vecs[i].r1 == vecs[i].wr) x1 = vecs[i].wd;
      if (vecs[i].r2 == vecs[i].wr) x2 = vecs[i].wd;
`endif
      #2;
      check($sformatf("vec%0d_rd1", i), readData1, x1);
      check($sformatf("vec%0d_rd2", i), readData2, x2);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle with a pending write to register 3 (holds 31, reg 4 holds 39).
    writeRegister = 3'd3;
    writeData     = 8'd99;
    readRegister1 = 3'd3;
    readRegister2 = 3'd4;
    #2;
    check("prereset_rd2", readData2, 8'd39);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd1", readData1, 8'd0);
    check("async_rst_rd2", readData2, 8'd0);
    @(posedge clk);
    #2;
    check("rst_hold_rd1", readData1, 8'd0);
    check("rst_hold_rd2", readData2, 8'd0);

    @(negedge clk);
    rst_n = 1'b1;
    writeRegister = 3'd2;
    writeData     = 8'd77;
    #2;
    check("post_rst_rd1", readData1, 8'd0);
    check("post_rst_rd2", readData2, 8'd0);
    @(posedge clk);
    #2;
    readRegister1 = 3'd2;
    writeRegister = 3'd6;
    writeData     = 8'd0;
    #1;
    check("first_write_rd1", readData1, 8'd77);
    check("lost_write_rd2", readData2, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
